// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back L1 data cache.
// Address split: tag [31:10], index [9:5], word select [4:2], byte offset [1:0].
// Holds the FSM state encoding and the per-line tag entry layout.
package dcache_pkg;

    localparam int TAG_W   = 22;
    localparam int IDX_W   = 5;
    localparam int OFS_W   = 5;
    localparam int IDX_LSB = OFS_W;
    localparam int TAG_LSB = OFS_W + IDX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2,
        REFILL    = 2'd3
    } state_t;

    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [TAG_W-1:0] tag;
    } tag_entry_t;

endpackage

// File: rtl/dcache_sram.sv
// Tag and data storage for the cache: asynchronous read, synchronous write.
// Ports: clk/rst, idx selects the line for both read and write; entry/data are the
//   read view; we/wr_entry/wr_data write the whole line. Reset clears valid/dirty only.
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int LINES      = 32,
    parameter int BLOCK_BITS = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [$clog2(LINES)-1:0]  idx,
    output tag_entry_t                entry,
    output logic [BLOCK_BITS-1:0]     data,
    input  logic                      we,
    input  tag_entry_t                wr_entry,
    input  logic [BLOCK_BITS-1:0]     wr_data
);

    logic [LINES-1:0]      valid_q;
    logic [LINES-1:0]      dirty_q;
    logic [TAG_W-1:0]      tag_q  [LINES];
    logic [BLOCK_BITS-1:0] data_q [LINES];

    assign entry.valid = valid_q[idx];
    assign entry.dirty = dirty_q[idx];
    assign entry.tag   = tag_q[idx];
    assign data        = data_q[idx];

    // Only the status bits need clearing; stale tags/data are masked by valid=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (we) begin
            valid_q[idx] <= wr_entry.valid;
            dirty_q[idx] <= wr_entry.dirty;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[idx]  <= wr_entry.tag;
            data_q[idx] <= wr_data;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back write-allocate L1 D-cache controller; hits answer in the same cycle.
// Ports: cpu_* from the MEM stage, stall_o freezes the pipeline on a miss, mem_* is the
//   256-bit block handshake (registered request, one-cycle ack). DCACHE_STATS_EN adds hit_cnt_o/miss_cnt_o.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int LINES      = 32,
    parameter int BLOCK_BITS = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [31:0]           cpu_addr_i,
    input  logic                  cpu_read_i,
    input  logic                  cpu_write_i,
    input  logic [31:0]           cpu_wdata_i,
    output logic [31:0]           cpu_rdata_o,
    output logic                  stall_o,
    output logic                  mem_enable_o,
    output logic                  mem_write_o,
    output logic [31:0]           mem_addr_o,
    output logic [BLOCK_BITS-1:0] mem_data_o,
    input  logic [BLOCK_BITS-1:0] mem_data_i,
    input  logic                  mem_ack_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]           hit_cnt_o,
    output logic [31:0]           miss_cnt_o
`endif
);

    state_t                state, next_state;
    logic [IDX_W-1:0]      idx;
    logic [TAG_W-1:0]      req_tag;
    logic [2:0]            wsel;
    logic [1:0]            addr_unused;
    tag_entry_t            entry, wr_entry;
    logic [BLOCK_BITS-1:0] line_data, wr_data, merged, refill_buf;
    logic [31:0]           line_word;
    logic                  req, hit, miss, idle, ack_seen, sram_we;

    assign idx         = cpu_addr_i[IDX_LSB +: IDX_W];
    assign req_tag     = cpu_addr_i[TAG_LSB +: TAG_W];
    assign wsel        = cpu_addr_i[OFS_W-1:2];
    assign addr_unused = cpu_addr_i[1:0];

    dcache_sram #(.LINES(LINES), .BLOCK_BITS(BLOCK_BITS)) u_sram (
        .clk      (clk_i),
        .rst      (rst_i),
        .idx      (idx),
        .entry    (entry),
        .data     (line_data),
        .we       (sram_we),
        .wr_entry (wr_entry),
        .wr_data  (wr_data)
    );

    assign idle      = (state == IDLE);
    assign req       = cpu_read_i | cpu_write_i;
    assign hit       = entry.valid && (entry.tag == req_tag);
    assign miss      = idle && req && !hit;
    assign stall_o   = !idle || miss;
    assign line_word = line_data[{wsel, 5'b0} +: 32];
    // Acks arriving while no transfer is outstanding are ignored.
    assign ack_seen  = mem_ack_i && (state == WRITEBACK || state == ALLOCATE);

    assign cpu_rdata_o = (idle && cpu_read_i && hit) ? line_word : 32'h0;

    always_comb begin
        merged = line_data;
        merged[{wsel, 5'b0} +: 32] = cpu_wdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:      if (miss) next_state = (entry.valid && entry.dirty) ? WRITEBACK : ALLOCATE;
            WRITEBACK: if (mem_ack_i) next_state = ALLOCATE;
            ALLOCATE:  if (mem_ack_i) next_state = REFILL;
            REFILL:    next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // Line update: refill installs a clean line; a store hit in IDLE (including the
    // re-evaluation right after a refill) merges its word and marks the line dirty.
    always_comb begin
        sram_we  = 1'b0;
        wr_entry = entry;
        wr_data  = line_data;
        if (state == REFILL) begin
            sram_we  = 1'b1;
            wr_entry = '{valid: 1'b1, dirty: 1'b0, tag: req_tag};
            wr_data  = refill_buf;
        end else if (idle && cpu_write_i && hit) begin
            sram_we  = 1'b1;
            wr_entry = '{valid: 1'b1, dirty: 1'b1, tag: req_tag};
            wr_data  = merged;
        end
    end

    always_ff @(posedge clk_i) begin
        if (state == ALLOCATE && mem_ack_i) refill_buf <= mem_data_i;
    end

    // Request registers load from next_state so a transfer starts in the first cycle of its
    // state. After an ack the request drops for one cycle, so a write-back followed by a
    // refill shows a one-cycle gap on mem_enable_o.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
        end else if (ack_seen) begin
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
        end else if (!mem_enable_o && next_state == WRITEBACK) begin
            mem_enable_o <= 1'b1;
            mem_write_o  <= 1'b1;
            mem_addr_o   <= {entry.tag, idx, 5'b0};
            mem_data_o   <= line_data;
        end else if (!mem_enable_o && next_state == ALLOCATE) begin
            mem_enable_o <= 1'b1;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= {req_tag, idx, 5'b0};
        end
    end

`ifdef DCACHE_STATS_EN
    // The IDLE cycle right after REFILL replays the missed request; it is not a new hit.
    logic post_refill;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            post_refill <= 1'b0;
            hit_cnt_o   <= '0;
            miss_cnt_o  <= '0;
        end else begin
            post_refill <= (state == REFILL);
            if (idle && req && hit && !post_refill && hit_cnt_o != 32'hFFFF_FFFF)
                hit_cnt_o <= hit_cnt_o + 32'd1;
            if (miss && miss_cnt_o != 32'hFFFF_FFFF)
                miss_cnt_o <= miss_cnt_o + 32'd1;
        end
    end
`endif

endmodule
